shiftreg_univ: RTL

- Parametrised W-bit universal shift register; successor to the 4-bit bidirectional shift register.
- Adds logical, rotate and arithmetic shift modes in both directions, plus a serial output.
- Adds an autonomous burst-shift engine: shift N times on Start, then pulse Done.
- Sits in serialiser/deserialiser and bit-manipulation datapaths.
- State updates on the falling edge of CLK, consistent with the existing shift-register family.

---
 rtl/shiftreg_univ_if.sv | 29 ++
 rtl/shiftreg_univ.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/shiftreg_univ_if.sv
// Bundles the control, data and status lines of the universal shift register.
// The master drives controls and load data; the slave returns register state and burst status.
interface shiftreg_univ_if #(
  parameter int W    = 8,
  parameter int CNTW = 4
);
  logic            LD;
  logic [W-1:0]    InP;
  logic            RL;
  logic [1:0]      Mode;
  logic            InS;
  logic            Step;
  logic            Start;
  logic [CNTW-1:0] Cnt;
  logic [W-1:0]    D;
  logic            SerOut;
  logic            Busy;
  logic            Done;

  modport master (
    output LD, InP, RL, Mode, InS, Step, Start, Cnt,
    input  D, SerOut, Busy, Done
  );

  modport slave (
    input  LD, InP, RL, Mode, InS, Step, Start, Cnt,
    output D, SerOut, Busy, Done
  );
endinterface

// File: rtl/shiftreg_univ.sv
// W-bit universal shift register with logical, rotate and arithmetic modes in both directions,
// a registered serial output and a counted burst-shift engine. All state moves on the falling CLK edge.
module shiftreg_univ #(
  parameter int W    = 8,
  parameter int CNTW = 4
) (
  input  logic            CLK,
  input  logic            Clear,
  shiftreg_univ_if.slave  bus
);

  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t          state_r;
  logic [W-1:0]    d_r;
  logic            serout_r;
  logic            busy_r;
  logic            done_r;
  logic [CNTW-1:0] rem_r;
  logic            rl_r;
  logic [1:0]      mode_r;

  logic            sel_rl_s;
  logic [1:0]      sel_mode_s;
  logic [W:0]      shift_s;
  logic            last_s;

  // One shift step: returns {bit shifted out, new register value}. Mode 11 falls back to logical.
  function automatic logic [W:0] shift_once(
    input logic [W-1:0] d,
    input logic         rl,
    input logic [1:0]   mode,
    input logic         ins
  );
    logic       fill;
    logic [W:0] res;
    if (rl) begin
      case (mode)
        MODE_ROT:   fill = d[W-1];
        MODE_ARITH: fill = 1'b0;
        default:    fill = ins;
      endcase
      res = {d[W-1], d[W-2:0], fill};
    end else begin
      case (mode)
        MODE_ROT:   fill = d[0];
        MODE_ARITH: fill = d[W-1];
        default:    fill = ins;
      endcase
      res = {d[0], fill, d[W-1:1]};
    end
    return res;
  endfunction

  // A burst uses the direction/mode captured at Start; a single Step uses the live controls.
  always_comb begin
    sel_rl_s   = bus.RL;
    sel_mode_s = bus.Mode;
    if (state_r == ST_SHIFT) begin
      sel_rl_s   = rl_r;
      sel_mode_s = mode_r;
    end else begin
      sel_rl_s   = bus.RL;
      sel_mode_s = bus.Mode;
    end
    shift_s = shift_once(d_r, sel_rl_s, sel_mode_s, bus.InS);
    last_s  = (rem_r == CNTW'(1));
  end

  // Register, serial output and burst FSM; Clear beats LD beats everything else.
  always_ff @(negedge CLK) begin
    if (Clear) begin
      state_r  <= ST_IDLE;
      d_r      <= '0;
      serout_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rem_r    <= '0;
      rl_r     <= 1'b0;
      mode_r   <= 2'b00;
    end else begin
      done_r <= 1'b0;
      if (bus.LD) begin
        d_r     <= bus.InP;
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
        rem_r   <= '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (bus.Start) begin
              // A zero-length burst completes immediately without touching the data.
              if (bus.Cnt == '0) begin
                done_r <= 1'b1;
              end else begin
                state_r <= ST_SHIFT;
                busy_r  <= 1'b1;
                rem_r   <= bus.Cnt;
                rl_r    <= bus.RL;
                mode_r  <= bus.Mode;
              end
            end else if (bus.Step) begin
              serout_r <= shift_s[W];
              d_r      <= shift_s[W-1:0];
            end else begin
              d_r <= d_r;
            end
          end
          ST_SHIFT: begin
            serout_r <= shift_s[W];
            d_r      <= shift_s[W-1:0];
            rem_r    <= rem_r - CNTW'(1);
            if (last_s) begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_SHIFT;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            rem_r   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.D      = d_r;
  assign bus.SerOut = serout_r;
  assign bus.Busy   = busy_r;
  assign bus.Done   = done_r;

endmodule
